// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver state encodings, default divider.
// Also intended for the matching transmitter.
package uart_pkg;

   localparam int PARITY_NONE     = 0;
   localparam int PARITY_ODD      = 1;
   localparam int PARITY_EVEN     = 2;

   // 12 MHz core clock / 115200 baud
   localparam int DEFAULT_CLK_DIV = 104;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_DONE   = 3'd5,
      ST_BREAK  = 3'd6
   } rx_state_t;

endpackage

// File: rtl/uart_rx_param_sync.sv
// Two-flop synchroniser for a single asynchronous input; output lags d by 2 cycles.
// Reset value is a parameter so idle-high and idle-low lines can both use it.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, optional parity, 1-2 stop bits; rxdone one cycle
// after the last stop-bit sample. No backpressure: each word is a one-cycle pulse, held until the next.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLK_DIV   = DEFAULT_CLK_DIV,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = PARITY_NONE,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 recvdata,
   output logic [DATA_BITS-1:0] rxbyte,
   output logic                 rxdone,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_LD  = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_LD  = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] LAST_DAT = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STP = BW'(STOP_BITS - 1);
   localparam logic          PAR_ODD  = (PARITY == PARITY_ODD);

   rx_state_t            state, state_nxt;
   logic [CW-1:0]        clk_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 fe_latch, pe_latch;
   logic                 rx_s;
   logic                 tick;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   assign tick   = (clk_cnt == '0);
   assign busy   = (state != ST_IDLE);
   assign rxdone = (state == ST_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (recvdata && !rx_s) state_nxt = ST_START;
         ST_START:  if (tick) state_nxt = rx_s ? ST_IDLE : ST_DATA;
         ST_DATA:   if (tick && bit_cnt == LAST_DAT)
                       state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
         ST_PARITY: if (tick) state_nxt = ST_STOP;
         ST_STOP:   if (tick && bit_cnt == LAST_STP) state_nxt = ST_DONE;
         // a line still low after the frame is a break, not a new start bit
         ST_DONE:   state_nxt = rx_s ? ST_IDLE : ST_BREAK;
         ST_BREAK:  if (rx_s) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         clk_cnt    <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         fe_latch   <= 1'b0;
         pe_latch   <= 1'b0;
         rxbyte     <= '0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state_nxt != state)
            clk_cnt <= (state_nxt == ST_START) ? HALF_LD : FULL_LD;
         else if (state == ST_IDLE || state == ST_BREAK)
            clk_cnt <= '0;
         else if (tick)
            clk_cnt <= FULL_LD;
         else
            clk_cnt <= clk_cnt - 1'b1;

         if (state_nxt != state)
            bit_cnt <= '0;
         else if (tick && (state == ST_DATA || state == ST_STOP))
            bit_cnt <= bit_cnt + 1'b1;

         if (state == ST_IDLE && state_nxt == ST_START) begin
            fe_latch <= 1'b0;
            pe_latch <= 1'b0;
         end

         // LSB-first: each new bit enters at the top and walks down
         if (state == ST_DATA && tick)
            shift <= {rx_s, shift[DATA_BITS-1:1]};

         if (state == ST_PARITY && tick)
            pe_latch <= (((^shift) ^ rx_s) != PAR_ODD);

         if (state == ST_STOP && tick)
            fe_latch <= fe_latch | ~rx_s;

         // results become visible together with the rxdone cycle
         if (state == ST_STOP && state_nxt == ST_DONE) begin
            rxbyte     <= shift;
            frame_err  <= fe_latch | ~rx_s;
            parity_err <= pe_latch;
         end
      end
   end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised 8N1-successor UART receiver. It takes the asynchronous rx line, synchronises it, and times bits from a clock divider rather than one bit per clk. It samples each bit at mid-period and supports configurable data width, parity and stop bits. It reports each received word with a one-cycle valid pulse and per-word framing and parity error flags, and feeds the echo/command path in the top level.

Parameters:
CLK_DIV, 104, clk cycles per bit period (104 = 12 MHz / 115200); legal range 4..65535
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits checked; 1 or 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
rx  input  1  asynchronous serial line; idles high
recvdata  input  1  receive enable; start bits are detected only while high
rxbyte  output  DATA_BITS  received word, LSB = first data bit; held until next rxdone
rxdone  output  1  one-cycle pulse: rxbyte, frame_err and parity_err are valid
frame_err  output  1  stop bit sampled low; valid with rxdone
parity_err  output  1  parity mismatch; valid with rxdone; always 0 when PARITY = 0
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state = IDLE; rxbyte = 0; rxdone = 0; frame_err = 0; parity_err = 0; busy = 0; bit/clock counters = 0; synchroniser flops = 1.
- rx passes through a 2-flop synchroniser (reset to 1). All references to rx below mean the synchronised value, which lags the pin by 2 cycles.
- Counters:
  - Clock counter: width clog2(CLK_DIV), counts 0..CLK_DIV-1.
  - Bit counter: width clog2(DATA_BITS+1).
- IDLE:
  - If recvdata = 1 and rx = 0: go to START and load clock counter for half-period (CLK_DIV/2, integer floor).
  - recvdata low: start bits are ignored.
- START:
  - At half-period, re-sample rx.
  - If rx = 1 (glitch/false start): return to IDLE, no rxdone.
  - If rx = 0: go to DATA; bit counter = 0; clock counter restarts a full period.
- DATA:
  - Every CLK_DIV cycles, sample rx and shift into the MSB of the shift register (LSB-first framing).
  - After DATA_BITS samples: go to PARITY if PARITY != 0, else STOP.
- PARITY:
  - Sample one bit after a full period.
  - parity_err = (XOR of data bits XOR sampled bit) != (PARITY == 1 ? 1 : 0); i.e. odd parity requires total ones odd.
- STOP:
  - Sample STOP_BITS bits, each one full period apart.
  - Any stop sample = 0 sets the frame error latch.
  - After the last stop sample: go to DONE.
- DONE (1 cycle):
  - Drive rxdone = 1; load rxbyte from the shift register; drive frame_err/parity_err from their latches.
  - Next state: IDLE if rx = 1, else BREAK.
- BREAK:
  - Wait until rx = 1, then go to IDLE. Prevents a held-low line (break) being re-read as a new start bit.
- rxdone is high exactly one cycle per accepted frame and 0 at all other times.
- frame_err/parity_err update only in the rxdone cycle and hold their values until the next rxdone.
- Latency: rxdone rises 1 cycle after the mid-point sample of the final stop bit, which is ~ (1 + DATA_BITS + P + STOP_BITS - 0.5) × CLK_DIV + 3 cycles after the rx pin falls, where P = 1 if PARITY != 0 else 0.
- recvdata deasserted mid-frame: the frame completes normally; recvdata gates only the IDLE → START transition.
- rst asserted mid-frame: return to IDLE on the next edge with all outputs at reset values; the partial frame is discarded and no rxdone is issued.
- Back-to-back frames: a start edge detected in the first IDLE cycle after DONE must be accepted, so there is no dead cycle beyond the DONE cycle.

Decomposition:
- Shared package uart_pkg holds:
  - Parity encodings PARITY_NONE = 0, PARITY_ODD = 1, PARITY_EVEN = 2.
  - State encodings IDLE, START, DATA, PARITY, STOP, DONE, BREAK (3-bit).
  - Default CLK_DIV for 12 MHz / 115200.
  The planned matching uart_tx_param shares the same package.
- One sub-module, sync_2ff: 1-bit, two-flop synchroniser with reset value parameter, reused for other async inputs.

Test Plan:
- CLK_DIV=8, 8N1, recvdata=1, send 0xA5 LSB-first → exactly one rxdone pulse; rxbyte=0xA5; frame_err=0; parity_err=0; busy returns to 0.
- CLK_DIV=8, PARITY=2, send 0x03 with parity bit 0, then 0x03 with parity bit 1 → first frame parity_err=0, second parity_err=1; rxbyte=0x03 both times.
- CLK_DIV=8, 8N1, send 0x55 with stop bit 0, then hold rx low 40 cycles, then high → one rxdone with frame_err=1; no second rxdone during the low hold; next frame 0x3C is received cleanly.
- CLK_DIV=8, pulse rx low 2 cycles only → no rxdone; busy falls within CLK_DIV/2+3 cycles.
- CLK_DIV=8, DATA_BITS=7, STOP_BITS=2, send 0x41 followed immediately by 0x7F with no idle gap → two rxdone pulses; rxbyte 0x41 then 0x7F; both frames error-free.
- Assert rst for 1 cycle mid-DATA of 0xFF, release, then send 0x12 → no rxdone for the aborted frame; next rxdone carries 0x12; recvdata=0 during a start edge produces no reception.
